lpm_table: RTL and testbench

Routing-table store and longest-prefix-match engine for the router output-port-lookup pipeline. Holds 32 route entries written and read over the table register interface. Runs pipelined LPM lookups on destination IPs and returns hit flag and entry index. Exposes every entry's {output queue, next hop} as flat 64-bit buses for the header-processing stage that consumes lookup results.

---
 rtl/lpm_table.sv | 229 ++++++++++++++++++++++
 tb/tb_lpm_table.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lpm_table.sv
// Routing-table store with a three-stage longest-prefix-match lookup pipeline.
// Table lines are {ip, mask, oq, nh}; a nonzero write validates an entry, a zero write clears it.
module lpm_table #(
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            AXI_ACLK,
    input  logic                            AXI_RESETN,
    input  logic                            tbl_wr_req,
    input  logic [4:0]                      tbl_wr_addr,
    input  logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
    output logic                            tbl_wr_ack,
    input  logic                            tbl_rd_req,
    input  logic [4:0]                      tbl_rd_addr,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
    output logic                            tbl_rd_ack,
    input  logic                            lookup_req,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   lookup_ip,
    output logic                            lookup_done,
    output logic                            lpm_hit_out,
    output logic [4:0]                      lpm_index_out,
    output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result0,  lpm_result1,  lpm_result2,  lpm_result3,
    output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result4,  lpm_result5,  lpm_result6,  lpm_result7,
    output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result8,  lpm_result9,  lpm_result10, lpm_result11,
    output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result12, lpm_result13, lpm_result14, lpm_result15,
    output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result16, lpm_result17, lpm_result18, lpm_result19,
    output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result20, lpm_result21, lpm_result22, lpm_result23,
    output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result24, lpm_result25, lpm_result26, lpm_result27,
    output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result28, lpm_result29, lpm_result30, lpm_result31,
    output logic [31:0]                     lpm_miss_count,
    input  logic                            counter_reset
);
    localparam int W = C_S_AXI_DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, WR_ACK, RD_ACK, RD_PEND} state_t;

    logic [4*W-1:0] lines [32];
    logic [31:0]    valid;
    state_t         state, state_next;
    logic           pend_rd;
    logic [4:0]     pend_addr;
    logic           wr_commit;

    logic [31:0]    match;
    logic           s1_valid;
    logic [31:0]    s1_match;
    logic [W-1:0]   s1_mask [32];

    logic           g_hit_c [4];
    logic [W-1:0]   g_mask_c [4];
    logic [4:0]     g_idx_c [4];
    logic           s2_valid;
    logic           g_hit [4];
    logic [W-1:0]   g_mask [4];
    logic [4:0]     g_idx [4];

    logic           fin_hit;
    logic [W-1:0]   fin_mask;
    logic [4:0]     fin_idx;

    assign wr_commit  = (state == IDLE) && tbl_wr_req;
    assign tbl_wr_ack = (state == WR_ACK);
    assign tbl_rd_ack = (state == RD_ACK);

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            for (int i = 0; i < 32; i++) lines[i] <= '0;
            valid <= '0;
        end else if (wr_commit) begin
            lines[tbl_wr_addr] <= tbl_wr_data;
            valid[tbl_wr_addr] <= |tbl_wr_data;
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            state       <= IDLE;
            pend_rd     <= 1'b0;
            pend_addr   <= '0;
            tbl_rd_data <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && tbl_wr_req) begin
                pend_rd   <= tbl_rd_req;
                pend_addr <= tbl_rd_addr;
            end else if (state == IDLE && tbl_rd_req) begin
                tbl_rd_data <= lines[tbl_rd_addr];
            end else if (state == RD_PEND) begin
                // The write has already landed, so this returns post-write contents.
                tbl_rd_data <= lines[pend_addr];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (tbl_wr_req)      state_next = WR_ACK;
                else if (tbl_rd_req) state_next = RD_ACK;
            end
            WR_ACK:  state_next = pend_rd ? RD_PEND : IDLE;
            RD_PEND: state_next = RD_ACK;
            RD_ACK:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < 32; i++) begin
            match[i] = valid[i] &&
                ((lookup_ip & lines[i][3*W-1:2*W]) == (lines[i][4*W-1:3*W] & lines[i][3*W-1:2*W]));
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            s1_valid <= 1'b0;
            s1_match <= '0;
            for (int i = 0; i < 32; i++) s1_mask[i] <= '0;
        end else begin
            s1_valid <= lookup_req;
            s1_match <= match;
            for (int i = 0; i < 32; i++) s1_mask[i] <= lines[i][3*W-1:2*W];
        end
    end

    // Strict greater-than keeps the lowest index on equal masks.
    always_comb begin
        for (int g = 0; g < 4; g++) begin
            g_hit_c[g]  = 1'b0;
            g_mask_c[g] = '0;
            g_idx_c[g]  = '0;
            for (int j = 0; j < 8; j++) begin
                if (s1_match[g*8+j] && (!g_hit_c[g] || s1_mask[g*8+j] > g_mask_c[g])) begin
                    g_hit_c[g]  = 1'b1;
                    g_mask_c[g] = s1_mask[g*8+j];
                    g_idx_c[g]  = 5'(g*8 + j);
                end
            end
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            s2_valid <= 1'b0;
            for (int g = 0; g < 4; g++) begin
                g_hit[g]  <= 1'b0;
                g_mask[g] <= '0;
                g_idx[g]  <= '0;
            end
        end else begin
            s2_valid <= s1_valid;
            for (int g = 0; g < 4; g++) begin
                g_hit[g]  <= g_hit_c[g];
                g_mask[g] <= g_mask_c[g];
                g_idx[g]  <= g_idx_c[g];
            end
        end
    end

    always_comb begin
        fin_hit  = 1'b0;
        fin_mask = '0;
        fin_idx  = '0;
        for (int g = 0; g < 4; g++) begin
            if (g_hit[g] && (!fin_hit || g_mask[g] > fin_mask)) begin
                fin_hit  = 1'b1;
                fin_mask = g_mask[g];
                fin_idx  = g_idx[g];
            end
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            lookup_done   <= 1'b0;
            lpm_hit_out   <= 1'b0;
            lpm_index_out <= '0;
        end else begin
            lookup_done   <= s2_valid;
            lpm_hit_out   <= s2_valid && fin_hit;
            lpm_index_out <= s2_valid ? fin_idx : 5'd0;
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            lpm_miss_count <= '0;
        end else if (counter_reset) begin
            lpm_miss_count <= '0;
        end else if (lookup_done && !lpm_hit_out && lpm_miss_count != 32'hFFFF_FFFF) begin
            lpm_miss_count <= lpm_miss_count + 32'd1;
        end
    end

    assign lpm_result0  = lines[0][2*W-1:0];
    assign lpm_result1  = lines[1][2*W-1:0];
    assign lpm_result2  = lines[2][2*W-1:0];
    assign lpm_result3  = lines[3][2*W-1:0];
    assign lpm_result4  = lines[4][2*W-1:0];
    assign lpm_result5  = lines[5][2*W-1:0];
    assign lpm_result6  = lines[6][2*W-1:0];
    assign lpm_result7  = lines[7][2*W-1:0];
    assign lpm_result8  = lines[8][2*W-1:0];
    assign lpm_result9  = lines[9][2*W-1:0];
    assign lpm_result10 = lines[10][2*W-1:0];
    assign lpm_result11 = lines[11][2*W-1:0];
    assign lpm_result12 = lines[12][2*W-1:0];
    assign lpm_result13 = lines[13][2*W-1:0];
    assign lpm_result14 = lines[14][2*W-1:0];
    assign lpm_result15 = lines[15][2*W-1:0];
    assign lpm_result16 = lines[16][2*W-1:0];
    assign lpm_result17 = lines[17][2*W-1:0];
    assign lpm_result18 = lines[18][2*W-1:0];
    assign lpm_result19 = lines[19][2*W-1:0];
    assign lpm_result20 = lines[20][2*W-1:0];
    assign lpm_result21 = lines[21][2*W-1:0];
    assign lpm_result22 = lines[22][2*W-1:0];
    assign lpm_result23 = lines[23][2*W-1:0];
    assign lpm_result24 = lines[24][2*W-1:0];
    assign lpm_result25 = lines[25][2*W-1:0];
    assign lpm_result26 = lines[26][2*W-1:0];
    assign lpm_result27 = lines[27][2*W-1:0];
    assign lpm_result28 = lines[28][2*W-1:0];
    assign lpm_result29 = lines[29][2*W-1:0];
    assign lpm_result30 = lines[30][2*W-1:0];
    assign lpm_result31 = lines[31][2*W-1:0];
endmodule

// File: tb/tb_lpm_table.sv
// Directed bench for lpm_table: lookups feed a scoreboard queue that a negedge monitor drains,
// while table accesses, counter and reset behaviour are checked inline.
module tb_lpm_table;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tbl_wr_req = 1'b0;
    logic [4:0]   tbl_wr_addr = '0;
    logic [127:0] tbl_wr_data = '0;
    logic         tbl_wr_ack;
    logic         tbl_rd_req = 1'b0;
    logic [4:0]   tbl_rd_addr = '0;
    logic [127:0] tbl_rd_data;
    logic         tbl_rd_ack;
    logic         lookup_req = 1'b0;
    logic [31:0]  lookup_ip = '0;
    logic         lookup_done;
    logic         lpm_hit_out;
    logic [4:0]   lpm_index_out;
    logic [63:0]  res [32];
    logic [31:0]  lpm_miss_count;
    logic         counter_reset = 1'b0;

    typedef struct packed {
        logic        hit;
        logic [4:0]  idx;
        logic [31:0] oq;
        logic [31:0] due;
    } exp_t;

    exp_t        sb [$];
    exp_t        popped;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    lpm_table #(.C_S_AXI_DATA_WIDTH(32)) dut (
        .AXI_ACLK(clk), .AXI_RESETN(rst_n),
        .tbl_wr_req(tbl_wr_req), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
        .tbl_wr_ack(tbl_wr_ack),
        .tbl_rd_req(tbl_rd_req), .tbl_rd_addr(tbl_rd_addr), .tbl_rd_data(tbl_rd_data),
        .tbl_rd_ack(tbl_rd_ack),
        .lookup_req(lookup_req), .lookup_ip(lookup_ip), .lookup_done(lookup_done),
        .lpm_hit_out(lpm_hit_out), .lpm_index_out(lpm_index_out),
        .lpm_result0(res[0]),   .lpm_result1(res[1]),   .lpm_result2(res[2]),   .lpm_result3(res[3]),
        .lpm_result4(res[4]),   .lpm_result5(res[5]),   .lpm_result6(res[6]),   .lpm_result7(res[7]),
        .lpm_result8(res[8]),   .lpm_result9(res[9]),   .lpm_result10(res[10]), .lpm_result11(res[11]),
        .lpm_result12(res[12]), .lpm_result13(res[13]), .lpm_result14(res[14]), .lpm_result15(res[15]),
        .lpm_result16(res[16]), .lpm_result17(res[17]), .lpm_result18(res[18]), .lpm_result19(res[19]),
        .lpm_result20(res[20]), .lpm_result21(res[21]), .lpm_result22(res[22]), .lpm_result23(res[23]),
        .lpm_result24(res[24]), .lpm_result25(res[25]), .lpm_result26(res[26]), .lpm_result27(res[27]),
        .lpm_result28(res[28]), .lpm_result29(res[29]), .lpm_result30(res[30]), .lpm_result31(res[31]),
        .lpm_miss_count(lpm_miss_count), .counter_reset(counter_reset)
    );

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one lookup and records what the monitor must see three cycles later.
    task automatic applyStimulus(input logic [31:0] ip, input logic hit, input logic [4:0] idx,
                                 input logic [31:0] oq);
        exp_t e;
        e.hit = hit;
        e.idx = idx;
        e.oq  = oq;
        e.due = cyc + 32'd3;
        sb.push_back(e);
        lookup_req = 1'b1;
        lookup_ip  = ip;
        tick();
        lookup_req = 1'b0;
    endtask

    task automatic writeEntry(input logic [4:0] addr, input logic [31:0] ip, input logic [31:0] mask,
                              input logic [31:0] oq, input logic [31:0] nh);
        tbl_wr_req  = 1'b1;
        tbl_wr_addr = addr;
        tbl_wr_data = {ip, mask, oq, nh};
        tick();
        tbl_wr_req = 1'b0;
        checkOutput("wr_ack", 128'(tbl_wr_ack), 128'd1);
        tick();
    endtask

    task automatic readEntry(input logic [4:0] addr, input logic [127:0] exp);
        tbl_rd_req  = 1'b1;
        tbl_rd_addr = addr;
        tick();
        tbl_rd_req = 1'b0;
        checkOutput("rd_ack", 128'(tbl_rd_ack), 128'd1);
        checkOutput("rd_data", tbl_rd_data, exp);
        tick();
        checkOutput("rd_ack_low", 128'(tbl_rd_ack), 128'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && lookup_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got lookup_done=1 at cycle %0d, expected none", cyc);
            end else begin
                popped = sb.pop_front();
                checkOutput("done_cycle", 128'(cyc), 128'(popped.due));
                checkOutput("hit", 128'(lpm_hit_out), 128'(popped.hit));
                checkOutput("index", 128'(lpm_index_out), 128'(popped.idx));
                if (popped.hit) checkOutput("result_oq", 128'(res[lpm_index_out][63:32]), 128'(popped.oq));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2;
        checkOutput("reset_done", 128'(lookup_done), 128'd0);
        checkOutput("reset_count", 128'(lpm_miss_count), 128'd0);
        checkOutput("reset_rd_data", tbl_rd_data, 128'd0);
        checkOutput("reset_result0", 128'(res[0]), 128'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Empty table: every lookup misses.
        applyStimulus(32'h0A00_0001, 1'b0, 5'd0, 32'd0);
        repeat (4) tick();
        checkOutput("miss_count_first", 128'(lpm_miss_count), 128'd1);

        writeEntry(5'd3, 32'h0A00_0000, 32'hFF00_0000, 32'd1, 32'h0A00_0002);
        writeEntry(5'd7, 32'h0A01_0000, 32'hFFFF_0000, 32'd2, 32'd0);
        checkOutput("result3_nh", 128'(res[3][31:0]), 128'h0A00_0002);
        applyStimulus(32'h0A01_0203, 1'b1, 5'd7, 32'd2);
        applyStimulus(32'h0A02_0001, 1'b1, 5'd3, 32'd1);
        repeat (4) tick();
        readEntry(5'd3, {32'h0A00_0000, 32'hFF00_0000, 32'd1, 32'h0A00_0002});

        writeEntry(5'd5, 32'd0, 32'd0, 32'd5, 32'd0);
        writeEntry(5'd2, 32'd0, 32'd0, 32'd4, 32'd0);
        applyStimulus(32'hC0A8_0101, 1'b1, 5'd2, 32'd4);
        repeat (4) tick();
        writeEntry(5'd2, 32'd0, 32'd0, 32'd0, 32'd0);
        applyStimulus(32'hC0A8_0101, 1'b1, 5'd5, 32'd5);
        repeat (4) tick();
        writeEntry(5'd5, 32'd0, 32'd0, 32'd0, 32'd0);

        // Write and read together: read returns the freshly written line three cycles on.
        tbl_wr_req  = 1'b1;
        tbl_rd_req  = 1'b1;
        tbl_wr_addr = 5'd9;
        tbl_rd_addr = 5'd9;
        tbl_wr_data = 128'h0B00_0000_FFFF_FFFF_0000_0003_0000_00AB;
        tick();
        tbl_wr_req = 1'b0;
        tbl_rd_req = 1'b0;
        checkOutput("sim_wr_ack", 128'(tbl_wr_ack), 128'd1);
        checkOutput("sim_rd_ack_early", 128'(tbl_rd_ack), 128'd0);
        tick();
        checkOutput("sim_pend_acks", 128'({tbl_wr_ack, tbl_rd_ack}), 128'd0);
        tick();
        checkOutput("sim_rd_ack", 128'(tbl_rd_ack), 128'd1);
        checkOutput("sim_rd_data", tbl_rd_data, 128'h0B00_0000_FFFF_FFFF_0000_0003_0000_00AB);
        tick();
        checkOutput("sim_rd_ack_low", 128'(tbl_rd_ack), 128'd0);
        checkOutput("sim_rd_hold", tbl_rd_data, 128'h0B00_0000_FFFF_FFFF_0000_0003_0000_00AB);

        // A write on the same edge as a lookup is invisible to that lookup only.
        tbl_wr_req  = 1'b1;
        tbl_wr_addr = 5'd0;
        tbl_wr_data = {32'hAC10_0000, 32'hFFF0_0000, 32'd6, 32'd0};
        applyStimulus(32'hAC10_0505, 1'b0, 5'd0, 32'd0);
        tbl_wr_req = 1'b0;
        applyStimulus(32'hAC10_0505, 1'b1, 5'd0, 32'd6);
        repeat (5) tick();
        checkOutput("miss_count_order", 128'(lpm_miss_count), 128'd2);

        counter_reset = 1'b1;
        tick();
        counter_reset = 1'b0;
        checkOutput("count_cleared", 128'(lpm_miss_count), 128'd0);
        applyStimulus(32'h0102_0304, 1'b0, 5'd0, 32'd0);
        applyStimulus(32'h7F00_0001, 1'b0, 5'd0, 32'd0);
        applyStimulus(32'hC0A8_0101, 1'b0, 5'd0, 32'd0);
        applyStimulus(32'h0B00_0001, 1'b0, 5'd0, 32'd0);
        repeat (5) tick();
        checkOutput("miss_count_four", 128'(lpm_miss_count), 128'd4);

        // counter_reset held during the done cycle of a miss must win.
        applyStimulus(32'h0808_0808, 1'b0, 5'd0, 32'd0);
        repeat (2) tick();
        checkOutput("coincident_done", 128'(lookup_done), 128'd1);
        counter_reset = 1'b1;
        tick();
        counter_reset = 1'b0;
        checkOutput("count_reset_wins", 128'(lpm_miss_count), 128'd0);
        tick();
        checkOutput("count_stays_zero", 128'(lpm_miss_count), 128'd0);

        // Reset while a lookup is in flight: it is dropped and everything clears.
        lookup_req = 1'b1;
        lookup_ip  = 32'h0A00_0009;
        tick();
        lookup_req = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_done", 128'(lookup_done), 128'd0);
        checkOutput("rst_hit_index", 128'({lpm_hit_out, lpm_index_out}), 128'd0);
        checkOutput("rst_acks", 128'({tbl_wr_ack, tbl_rd_ack}), 128'd0);
        checkOutput("rst_rd_data", tbl_rd_data, 128'd0);
        checkOutput("rst_result3", 128'(res[3]), 128'd0);
        checkOutput("rst_result9", 128'(res[9]), 128'd0);
        checkOutput("rst_count", 128'(lpm_miss_count), 128'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        applyStimulus(32'h0A00_0001, 1'b0, 5'd0, 32'd0);
        repeat (5) tick();
        checkOutput("post_reset_count", 128'(lpm_miss_count), 128'd1);

        checkOutput("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
